// File: rtl/ecap5_dproc_pkg.sv
// ecap5_dproc_pkg: shared types and constants for the data-path blocks
package ecap5_dproc_pkg;
  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WAIT = 2'd1,
    WB_ACK  = 2'd2
  } wb_slave_state_t;
  localparam logic [3:0] WB_SEL_ALL = 4'hF;
endpackage

// File: rtl/wb_mem_slave_if.sv
// wb_mem_slave_if: Wishbone classic bus between the load/store master and the memory slave
interface wb_mem_slave_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic        wb_cyc_i;
  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o
  );
  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_mem_slave_byte_en_ram.sv
// byte_en_ram: 32-bit wide RAM with byte-enabled sync write and sync read-first read
module byte_en_ram #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/wb_mem_slave.sv
// wb_mem_slave: Wishbone classic slave RAM with address window decode and programmable wait states
module wb_mem_slave
  import ecap5_dproc_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic           clk_i,
  input logic           rst_i,
  wb_mem_slave_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE = WB_IDLE;
  localparam logic [1:0] S_WAIT = WB_WAIT;
  localparam logic [1:0] S_ACK  = WB_ACK;
  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [AW-1:0] req_idx;
  logic          req_hit, req_we;
  logic [3:0]    req_sel;
  logic [31:0]   req_dat;
  logic [29:0]   off;
  logic          hit, req, in_idle, enter_ack, ram_we;
  logic [AW-1:0] ram_idx;
  logic [3:0]    ram_sel;
  logic [31:0]   ram_wdat, ram_q;
  assign off     = bus.wb_adr_i[31:2] - BASE_ADDR[31:2];
  assign hit     = bus.wb_adr_i >= BASE_ADDR && off < 30'(DEPTH_WORDS);
  assign req     = bus.wb_cyc_i & bus.wb_stb_i;
  assign in_idle = state == S_IDLE;
  // With zero wait states the RAM is accessed on the capture edge, so it sees the live bus
  always_comb begin
    enter_ack = ~rst_i & (in_idle ? req && WAIT_CYCLES == 0 : state == S_WAIT && req && cnt == 4'd0);
    ram_we    = enter_ack & (in_idle ? bus.wb_we_i & hit : req_we & req_hit);
    ram_idx   = in_idle ? off[AW-1:0] : req_idx;
    ram_sel   = in_idle ? bus.wb_sel_i : req_sel;
    ram_wdat  = in_idle ? bus.wb_dat_i : req_dat;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else if (state == S_IDLE) begin
      if (req) begin
        state <= WAIT_CYCLES == 0 ? S_ACK : S_WAIT;
        cnt   <= WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
      end
    end else if (state == S_WAIT) begin
      state <= !req ? S_IDLE : cnt == 4'd0 ? S_ACK : S_WAIT;
      cnt   <= cnt == 4'd0 ? cnt : cnt - 4'd1;
    end else begin
      state <= S_IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (in_idle && req) begin
      req_idx <= off[AW-1:0];
      req_hit <= hit;
      req_we  <= bus.wb_we_i;
      req_sel <= bus.wb_sel_i;
      req_dat <= bus.wb_dat_i;
    end
  end
  byte_en_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk_i),
    .we    (ram_we),
    .be    (ram_sel),
    .waddr (ram_idx),
    .wdata (ram_wdat),
    .re    (enter_ack),
    .raddr (ram_idx),
    .rdata (ram_q)
  );
  assign bus.wb_ack_o = state == S_ACK;
  assign bus.wb_dat_o = (state == S_ACK && !req_we && req_hit) ? ram_q : 32'h0;
endmodule

// File: tb/tb_wb_mem_slave.sv
// tb_wb_mem_slave: four slave configurations driven by one shared master, checked against a scoreboard
module tb_wb_mem_slave;
  import ecap5_dproc_pkg::*;
  localparam int          WS  [4] = '{0, 3, 0, 2};
  localparam int          DEP [4] = '{1024, 1024, 16, 1024};
  localparam logic [31:0] BA  [4] = '{32'h0, 32'h0, 32'h1000_0000, 32'h0};
  typedef struct {
    logic        chk;
    logic [31:0] dat;
  } exp_t;
  exp_t sb[$];
  logic        clk = 0, rst = 1, we = 0, stb = 0, cyc = 0;
  logic [3:0]  sel = 0;
  logic [31:0] adr = 0, wdat = 0;
  logic [3:0]  ack_v;
  logic [31:0] dat_v [4];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    wb_mem_slave_if bus ();
    assign bus.wb_adr_i = adr;
    assign bus.wb_dat_i = wdat;
    assign bus.wb_we_i  = we;
    assign bus.wb_sel_i = sel;
    assign bus.wb_stb_i = stb;
    assign bus.wb_cyc_i = cyc;
    assign ack_v[g] = bus.wb_ack_o;
    assign dat_v[g] = bus.wb_dat_o;
    wb_mem_slave #(.DEPTH_WORDS(DEP[g]), .WAIT_CYCLES(WS[g]), .BASE_ADDR(BA[g])) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
    );
  end
  task automatic idle_bus();
    cyc = 0;
    stb = 0;
    we  = 0;
  endtask
  task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic chk, input logic [31:0] want);
    exp_t e;
    int lat = 0;
    sb.push_back('{chk, want});
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    while (lat == 0 || (!ack_v[k] && lat < 40)) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (ack_v[k] !== 1'b1 || lat != 1 + WS[k]) begin
      errors++;
      $display("FAIL ack_latency dut%0d adr=%h: got ack=%b after %0d cycles, want ack after %0d", k, a, ack_v[k], lat, 1 + WS[k]);
    end
    e = sb.pop_front();
    if (e.chk) begin
      checks++;
      if (dat_v[k] !== e.dat) begin
        errors++;
        $display("FAIL read_data dut%0d adr=%h: got %h, want %h", k, a, dat_v[k], e.dat);
      end
    end
    idle_bus();
    @(negedge clk);
    checks++;
    if (ack_v[k] !== 1'b0 || dat_v[k] !== 32'h0) begin
      errors++;
      $display("FAIL ack_pulse dut%0d adr=%h: got ack=%b dat=%h, want ack=0 dat=0", k, a, ack_v[k], dat_v[k]);
    end
  endtask
  task automatic no_ack_for(input int k, input int n, input string name);
    logic bad = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      bad |= ack_v[k];
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s dut%0d: got an ack, want none", name, k);
    end
  endtask
  task automatic test_reset();
    int first [4] = '{0, 0, 0, 0};
    rst = 1; cyc = 1; stb = 1; we = 0; adr = 32'h10; sel = WB_SEL_ALL;
    repeat (2) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ack_v[k] !== 1'b0 || dat_v[k] !== 32'h0) begin
          errors++;
          $display("FAIL reset_outputs dut%0d: got ack=%b dat=%h, want ack=0 dat=0", k, ack_v[k], dat_v[k]);
        end
      end
    end
    rst = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (ack_v[k] && first[k] == 0) first[k] = c;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (first[k] != 1 + WS[k]) begin
        errors++;
        $display("FAIL reset_first_ack dut%0d: got first ack at cycle %0d, want %0d", k, first[k], 1 + WS[k]);
      end
    end
    idle_bus();
    @(negedge clk);
  endtask
  task automatic test_word();
    xfer(0, 1, 32'h10, 32'hDEAD_BEEF, WB_SEL_ALL, 0, 0);
    xfer(0, 0, 32'h10, 0, WB_SEL_ALL, 1, 32'hDEAD_BEEF);
  endtask
  task automatic test_byte_lanes();
    xfer(0, 1, 32'h10, 32'h1122_3344, 4'b0101, 0, 0);
    xfer(0, 0, 32'h10, 0, WB_SEL_ALL, 1, 32'hDE22_BE44);
    xfer(0, 1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 0, 0);
    xfer(0, 0, 32'h10, 0, 4'b0001, 1, 32'hDE22_BE44);
  endtask
  task automatic test_wait_states();
    xfer(1, 1, 32'h30, 32'hCAFE_F00D, WB_SEL_ALL, 0, 0);
    xfer(1, 0, 32'h30, 0, WB_SEL_ALL, 1, 32'hCAFE_F00D);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'h30; wdat = 32'h1234_5678; sel = WB_SEL_ALL;
    repeat (2) @(negedge clk);
    cyc = 0;
    no_ack_for(1, 6, "wait_abort");
    idle_bus();
    xfer(1, 0, 32'h30, 0, WB_SEL_ALL, 1, 32'hCAFE_F00D);
  endtask
  task automatic test_out_of_range();
    for (int i = 0; i < 16; i++)
      xfer(2, 1, 32'h1000_0000 + 32'(4 * i), 32'hA500_0000 | 32'(i), WB_SEL_ALL, 0, 0);
    xfer(2, 1, 32'h1000_0040, 32'hFFFF_FFFF, WB_SEL_ALL, 0, 0);
    xfer(2, 0, 32'h0FFF_FFFC, 0, WB_SEL_ALL, 1, 32'h0);
    xfer(2, 0, 32'h1000_0040, 0, WB_SEL_ALL, 1, 32'h0);
    for (int i = 0; i < 16; i++)
      xfer(2, 0, 32'h1000_0000 + 32'(4 * i), 0, WB_SEL_ALL, 1, 32'hA500_0000 | 32'(i));
  endtask
  task automatic test_back_to_back();
    exp_t e;
    int n = 0;
    repeat (3) sb.push_back('{1'b1, 32'hA500_0001});
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h1000_0004; sel = WB_SEL_ALL;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (ack_v[2] !== 1'((c % 2) == 1)) begin
        errors++;
        $display("FAIL b2b_ack_pattern cycle %0d: got ack=%b, want %b", c, ack_v[2], (c % 2) == 1);
      end
      if (ack_v[2] && sb.size() > 0) begin
        e = sb.pop_front();
        n++;
        checks++;
        if (dat_v[2] !== e.dat) begin
          errors++;
          $display("FAIL b2b_data cycle %0d: got %h, want %h", c, dat_v[2], e.dat);
        end
      end
    end
    idle_bus();
    no_ack_for(2, 3, "b2b_trailing_ack");
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL b2b_ack_count: got %0d, want 3", n);
    end
    sb.delete();
  endtask
  task automatic test_reset_mid();
    xfer(3, 1, 32'h20, 32'h0BAD_F00D, WB_SEL_ALL, 0, 0);
    for (int v = 1; v <= 2; v++) begin
      @(negedge clk);
      cyc = 1; stb = 1; we = 1; adr = 32'h20; wdat = 32'hFFFF_FFFF; sel = WB_SEL_ALL;
      repeat (v) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      idle_bus();
      checks++;
      if (ack_v[3] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_ack variant %0d: got ack=%b, want 0", v, ack_v[3]);
      end
      no_ack_for(3, 4, "reset_mid_late_ack");
      xfer(3, 0, 32'h20, 0, WB_SEL_ALL, 1, 32'h0BAD_F00D);
    end
  endtask
  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_wait_states();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_mem_slave.md
# wb_mem_slave

Wishbone classic (B4, non-pipelined) slave memory responding to the `exm` stage's load/store master port. Decodes a word-addressed window, services byte-lane writes and full-word reads, and inserts a programmable number of wait states before acknowledging. Used as the data memory model in stage and core benches, and as a synthesizable on-chip data RAM.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, ≥ 4.
- `WAIT_CYCLES`, 0: extra cycles between request capture and `wb_ack_o`; range 0–15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.

Ports:
- `clk_i` in 1: clock; all logic on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `wb_adr_i` in 32: byte address; bits [1:0] ignored.
- `wb_dat_i` in 32: write data from master.
- `wb_dat_o` out 32: read data; valid only while `wb_ack_o`=1.
- `wb_we_i` in 1: 1 = write, 0 = read.
- `wb_sel_i` in 4: byte-lane enables; bit n covers bits [8n+7:8n].
- `wb_stb_i` in 1: strobe.
- `wb_ack_o` out 1: acknowledge, single-cycle pulse.
- `wb_cyc_i` in 1: bus cycle in progress.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE: if `wb_cyc_i & wb_stb_i`, capture adr/dat/we/sel into request registers; go to WAIT if `WAIT_CYCLES`>0 (load counter with `WAIT_CYCLES-1`), else ACK.
- WAIT: decrement counter each cycle; at 0 go to ACK. If `wb_cyc_i` or `wb_stb_i` drops, abort → IDLE, no ack, no write.
- ACK: `wb_ack_o`=1 for exactly this cycle; always return to IDLE.
- Decode: in range iff `adr >= BASE_ADDR` and `(adr-BASE_ADDR)>>2 < DEPTH_WORDS`; index = `(adr-BASE_ADDR)>>2`, `$clog2(DEPTH_WORDS)` bits.
- Write: committed at the clock edge entering ACK; only lanes with sel=1 updated; sel=4'b0000 writes nothing but still acks.
- Read: `wb_dat_o` = full word at index, registered on entry to ACK; `sel` does not mask read data.
- Out of range: acked normally; writes discarded; reads return 32'h0000_0000.
- `wb_dat_o` = 0 whenever `wb_ack_o`=0.
- Captured request is used throughout; master changes to adr/dat/sel after capture are ignored.

## Timing
- Reset: state=IDLE, `wb_ack_o`=0, `wb_dat_o`=0, counter=0. Memory contents not cleared.
- Latency: request sampled in cycle N (IDLE) → `wb_ack_o` high in cycle N+1+`WAIT_CYCLES`.
- Throughput: one transaction per 2+`WAIT_CYCLES` cycles; IDLE follows every ACK, so a held `stb` is never double-serviced in the ack cycle; a still-asserted request in the IDLE cycle after ACK is a new transaction.
- Read-after-write to same word in consecutive transactions returns the new data.
- Reset asserted in WAIT or ACK: next cycle IDLE, ack 0; a write whose ACK-entry edge coincides with `rst_i`=1 is not committed.
- `wb_cyc_i`=1 with `wb_stb_i`=0 in IDLE: no capture.

## Structure
- Add to `ecap5_dproc_pkg`: `wb_slave_state_t` enum (IDLE, WAIT, ACK); constant `WB_SEL_ALL = 4'hF`.
- One natural sub-module: `byte_en_ram` (DEPTH_WORDS × 32, one sync write port with 4 byte enables, one sync read port), so FPGA targets infer block RAM; FSM, decode and wait counter stay in `wb_mem_slave`.

## Test plan
- Reset: hold `rst_i` 2 cycles with `cyc`=`stb`=1 → `wb_ack_o`=0, `wb_dat_o`=0 throughout; first ack 1+`WAIT_CYCLES` cycles after release.
- Word write/read, `WAIT_CYCLES`=0: write 32'hDEADBEEF to 0x10, sel=4'hF → ack in cycle N+1; read 0x10 → `wb_dat_o`=32'hDEADBEEF with ack.
- Byte lanes: over 32'hDEADBEEF write 32'h11223344 with sel=4'b0101 → read returns 32'hDE22BE44; sel=4'b0000 write leaves it unchanged and still acks.
- Wait states, `WAIT_CYCLES`=3: read sampled cycle N → ack only in N+4; drop `cyc` at N+2 on a write → no ack, memory unchanged.
- Out of range, `BASE_ADDR`=32'h1000_0000, `DEPTH_WORDS`=16: write 0x1000_0040 → acked, no word modified; read 0x0FFF_FFFC → ack with 32'h0; held `stb` across 3 back-to-back reads → exactly 3 acks, each separated by one IDLE cycle.
- Reset mid-operation, `WAIT_CYCLES`=2: assert `rst_i` in WAIT of a write to 0x20 → no ack, word at 0x20 unchanged on readback.
